// File: rtl/acondicionador_sensores_pkg.sv
// Shared definitions for the beam-sensor conditioning block.
// The per-channel filter state encoding lives here so the top and the bench agree on it.
package acondicionador_sensores_pkg;

    typedef enum logic {
        ESTABLE   = 1'b0,
        VALIDANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/debounce_canal.sv
// One beam channel: 2-flop synchroniser, polarity fix, stable-sample debounce FSM
// and a stuck-beam monitor. All filtering advances only on the shared sample tick.
module debounce_canal
    import acondicionador_sensores_pkg::*;
#(
    parameter int STABLE_SAMPLES = 10,
    parameter int STUCK_SAMPLES  = 30000,
    parameter bit RAW_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic out,
    output logic atascado
);

    localparam int CNT_W   = $clog2(STABLE_SAMPLES + 1);
    localparam int STUCK_W = $clog2(STUCK_SAMPLES + 1);

    logic [1:0]         sync;
    logic               s_x;
    estado_t            state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               out_n;
    logic [STUCK_W-1:0] stuck_cnt, stuck_n;

    // Sync flops reset to the idle raw level so s_x starts inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= {2{RAW_ACTIVE_LOW}};
            state     <= ESTABLE;
            cnt       <= '0;
            out       <= 1'b0;
            stuck_cnt <= '0;
        end else begin
            sync      <= {sync[0], raw};
            state     <= state_n;
            cnt       <= cnt_n;
            out       <= out_n;
            stuck_cnt <= stuck_n;
        end
    end

    assign s_x = sync[1] ^ RAW_ACTIVE_LOW;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out;
        if (tick) begin
            case (state)
                ESTABLE: begin
                    if (s_x != out) begin
                        if (STABLE_SAMPLES == 1) begin
                            out_n = ~out;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = VALIDANDO;
                        end
                    end
                end
                VALIDANDO: begin
                    if (s_x == out) begin
                        cnt_n   = '0;
                        state_n = ESTABLE;
                    end else if (cnt + 1'b1 == CNT_W'(STABLE_SAMPLES)) begin
                        out_n   = ~out;
                        cnt_n   = '0;
                        state_n = ESTABLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = ESTABLE;
                end
            endcase
        end
    end

    // Stuck counter clears on any clock with the output low, not just on ticks.
    always_comb begin
        stuck_n = stuck_cnt;
        if (!out)
            stuck_n = '0;
        else if (tick && stuck_cnt != STUCK_W'(STUCK_SAMPLES))
            stuck_n = stuck_cnt + 1'b1;
    end

    assign atascado = (stuck_cnt == STUCK_W'(STUCK_SAMPLES));

endmodule

// File: rtl/acondicionador_sensores.sv
// Gate beam-sensor conditioner: shared sample prescaler feeding two independent
// debounce channels (entry and exit).
module acondicionador_sensores
    import acondicionador_sensores_pkg::*;
#(
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 10,
    parameter int STUCK_SAMPLES  = 30000,
    parameter bit RAW_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_entra_raw,
    input  logic sensor_sale_raw,
    output logic entra,
    output logic sale,
    output logic atascado_entra,
    output logic atascado_sale,
    output logic tick_muestreo
);

    localparam int PRESC_W = $clog2(SAMPLE_DIV);

    logic [PRESC_W-1:0] presc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (tick_muestreo)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign tick_muestreo = (presc == PRESC_W'(SAMPLE_DIV - 1));

    debounce_canal #(
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .STUCK_SAMPLES (STUCK_SAMPLES),
        .RAW_ACTIVE_LOW(RAW_ACTIVE_LOW)
    ) u_entra (
        .clk     (clk),
        .reset   (reset),
        .raw     (sensor_entra_raw),
        .tick    (tick_muestreo),
        .out     (entra),
        .atascado(atascado_entra)
    );

    debounce_canal #(
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .STUCK_SAMPLES (STUCK_SAMPLES),
        .RAW_ACTIVE_LOW(RAW_ACTIVE_LOW)
    ) u_sale (
        .clk     (clk),
        .reset   (reset),
        .raw     (sensor_sale_raw),
        .tick    (tick_muestreo),
        .out     (sale),
        .atascado(atascado_sale)
    );

endmodule

// File: tb/tb_acondicionador_sensores.sv
// Directed bench: SAMPLE_DIV=4, STABLE_SAMPLES=3, STUCK_SAMPLES=5, with a second
// instance using active-low raw sensors for the polarity/concurrency scenario.
module tb_acondicionador_sensores;
    import acondicionador_sensores_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic raw_e, raw_s, raw_al_e, raw_al_s;
    logic entra, sale, at_e, at_s, tick;
    logic al_e, al_s, al_at_e, al_at_s, al_tick;

    int checks = 0;
    int errors = 0;

    int cyc;
    int n_rise_e, n_rise_s, n_fall_s, n_tick;
    int at_rise_e, at_fall_e, at_rise_s, at_rise_ae, at_fall_ae, at_rise_ale, at_rise_als, at_tick;
    logic p_e, p_s, p_ae, p_ale, p_als;

    always #5 clk = ~clk;

    acondicionador_sensores #(
        .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .STUCK_SAMPLES(5), .RAW_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .sensor_entra_raw(raw_e), .sensor_sale_raw(raw_s),
        .entra(entra), .sale(sale),
        .atascado_entra(at_e), .atascado_sale(at_s),
        .tick_muestreo(tick)
    );

    acondicionador_sensores #(
        .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .STUCK_SAMPLES(5), .RAW_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset(reset),
        .sensor_entra_raw(raw_al_e), .sensor_sale_raw(raw_al_s),
        .entra(al_e), .sale(al_s),
        .atascado_entra(al_at_e), .atascado_sale(al_at_s),
        .tick_muestreo(al_tick)
    );

    // Restart the cycle counter and edge records at the current negedge.
    task clear_rec();
        cyc = 0;
        n_rise_e = 0; n_rise_s = 0; n_fall_s = 0; n_tick = 0;
        at_rise_e = -1; at_fall_e = -1; at_rise_s = -1; at_rise_ae = -1;
        at_fall_ae = -1; at_rise_ale = -1; at_rise_als = -1; at_tick = -1;
        p_e = entra; p_s = sale; p_ae = at_e; p_ale = al_e; p_als = al_s;
    endtask

    task step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (entra && !p_e) begin n_rise_e++; if (at_rise_e < 0) at_rise_e = cyc; end
            if (!entra && p_e && at_fall_e < 0) at_fall_e = cyc;
            if (sale && !p_s) begin n_rise_s++; if (at_rise_s < 0) at_rise_s = cyc; end
            if (!sale && p_s) n_fall_s++;
            if (at_e && !p_ae && at_rise_ae < 0) at_rise_ae = cyc;
            if (!at_e && p_ae && at_fall_ae < 0) at_fall_ae = cyc;
            if (al_e && !p_ale && at_rise_ale < 0) at_rise_ale = cyc;
            if (al_s && !p_als && at_rise_als < 0) at_rise_als = cyc;
            if (tick) begin n_tick++; if (at_tick < 0) at_tick = cyc; end
            p_e = entra; p_s = sale; p_ae = at_e; p_ale = al_e; p_als = al_s;
        end
    endtask

    // Align to a negedge where the sample strobe is high; bounded.
    task wait_tick();
        int i;
        for (i = 0; i < 8 && !tick; i++) @(negedge clk);
        checks++;
        if (!tick) begin
            errors++;
            $display("FAIL wait_tick: tick_muestreo=%b after %0d cycles, required 1", tick, i);
        end
    endtask

    task test_reset();
        reset = 1'b1; raw_e = 1'b0; raw_s = 1'b0; raw_al_e = 1'b1; raw_al_s = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({entra, sale, at_e, at_s, tick} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000", {entra, sale, at_e, at_s, tick});
        end
        checks++;
        if ({al_e, al_s, al_at_e, al_at_s, al_tick} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_al: got %b, required 00000", {al_e, al_s, al_at_e, al_at_s, al_tick});
        end
        reset = 1'b0;
        clear_rec();
        step(16);
        checks++;
        if (at_tick !== 3) begin
            errors++;
            $display("FAIL first_tick: cycle %0d, required 3", at_tick);
        end
        checks++;
        if (n_tick !== 4) begin
            errors++;
            $display("FAIL tick_count: %0d in 16 cycles, required 4", n_tick);
        end
    endtask

    task test_clean_press();
        wait_tick();
        raw_e = 1'b1;
        clear_rec();
        step(25);
        checks++;
        if (at_rise_e !== 13) begin
            errors++;
            $display("FAIL press_latency: entra rose at %0d, required 13", at_rise_e);
        end
        checks++;
        if (n_rise_e !== 1) begin
            errors++;
            $display("FAIL press_edges: %0d rising edges, required 1", n_rise_e);
        end
        checks++;
        if (n_rise_s !== 0 || sale !== 1'b0) begin
            errors++;
            $display("FAIL press_sale_quiet: sale=%b rises=%0d, required 0/0", sale, n_rise_s);
        end
    endtask

    // Continues the clean-press record: entra rose at cycle 13.
    task test_stuck();
        step(15);
        checks++;
        if (at_rise_ae !== 33) begin
            errors++;
            $display("FAIL stuck_rise: atascado_entra rose at %0d, required 33", at_rise_ae);
        end
        checks++;
        if ({entra, at_e} !== 2'b11) begin
            errors++;
            $display("FAIL stuck_hold: entra,atascado=%b, required 11", {entra, at_e});
        end
        wait_tick();
        raw_e = 1'b0;
        clear_rec();
        step(20);
        checks++;
        if (at_fall_e !== 13) begin
            errors++;
            $display("FAIL release_latency: entra fell at %0d, required 13", at_fall_e);
        end
        checks++;
        if (at_fall_ae !== 14) begin
            errors++;
            $display("FAIL stuck_clear: atascado_entra fell at %0d, required 14", at_fall_ae);
        end
        checks++;
        if (n_rise_e !== 0) begin
            errors++;
            $display("FAIL release_edges: %0d spurious entra rises, required 0", n_rise_e);
        end
    endtask

    task test_glitch();
        wait_tick();
        raw_e = 1'b1;
        clear_rec();
        step(6);
        raw_e = 1'b0;
        step(24);
        checks++;
        if (n_rise_e !== 0) begin
            errors++;
            $display("FAIL glitch_reject: entra rose %0d times, required 0", n_rise_e);
        end
        checks++;
        if (dut.u_entra.state !== ESTABLE) begin
            errors++;
            $display("FAIL glitch_state: state=%0d, required ESTABLE", dut.u_entra.state);
        end
    endtask

    task test_bounce();
        wait_tick();
        clear_rec();
        for (int k = 0; k < 50; k++) begin
            if (k < 30 && k % 3 == 0) raw_s = ~raw_s;
            else if (k == 30) raw_s = 1'b1;
            step(1);
        end
        checks++;
        if (n_rise_s !== 1) begin
            errors++;
            $display("FAIL bounce_edges: sale rose %0d times, required 1", n_rise_s);
        end
        checks++;
        if (at_rise_s !== 37) begin
            errors++;
            $display("FAIL bounce_latency: sale rose at %0d, required 37", at_rise_s);
        end
        checks++;
        if (n_fall_s !== 0) begin
            errors++;
            $display("FAIL bounce_falls: sale fell %0d times, required 0", n_fall_s);
        end
    endtask

    task test_reset_mid();
        wait_tick();
        raw_e = 1'b1;
        clear_rec();
        step(14);
        wait_tick();
        raw_e = 1'b0;
        clear_rec();
        step(5);
        checks++;
        if (dut.u_entra.state !== VALIDANDO || entra !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: state=%0d entra=%b, required VALIDANDO/1", dut.u_entra.state, entra);
        end
        raw_e = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({entra, sale, at_e, at_s, tick} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, required 00000", {entra, sale, at_e, at_s, tick});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_rec();
        step(20);
        checks++;
        if (at_rise_e !== 12) begin
            errors++;
            $display("FAIL requalify_entra: rose at %0d, required 12", at_rise_e);
        end
        checks++;
        if (at_rise_s !== 12) begin
            errors++;
            $display("FAIL requalify_sale: rose at %0d, required 12", at_rise_s);
        end
    endtask

    task test_polarity_concurrent();
        wait_tick();
        raw_al_e = 1'b0;
        raw_al_s = 1'b0;
        clear_rec();
        step(16);
        checks++;
        if (at_rise_ale !== 13) begin
            errors++;
            $display("FAIL al_entra_rise: at %0d, required 13", at_rise_ale);
        end
        checks++;
        if (at_rise_als !== at_rise_ale || at_rise_als !== 13) begin
            errors++;
            $display("FAIL al_same_edge: sale at %0d entra at %0d, required 13/13", at_rise_als, at_rise_ale);
        end
        checks++;
        if ({al_e, al_s} !== 2'b11) begin
            errors++;
            $display("FAIL al_both_high: got %b, required 11", {al_e, al_s});
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_stuck();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_polarity_concurrent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
